data_sram_responder: RTL and testbench

- Responder (slave) end of the data SRAM-like request/response interface driven by the EX/MEM stages.
- Accepts one request per cycle on req/addr_ok and performs writes at acceptance.
- Returns one data_ok pulse per accepted request, strictly in order, with read data.
- Backed by an internal word-addressed memory; serves as the memory model for pipeline benches and as a template for the later AXI bridge.

---
 rtl/data_sram_responder.sv | 100 ++++++++++
 tb/tb_data_sram_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - in-order SRAM-like responder with a word-addressed backing memory
// Optional DATA_SRAM_RAND_DELAY_EN: LFSR-driven random stalls on addr_ok and data_ok.
module data_sram_responder #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 4,
  parameter int RESP_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(RESP_LAT + 1);

  logic [31:0]       mem [0:(2**ADDR_W)-1];
  logic [31:0]       q_data [DEPTH];
  logic [DEPTH-1:0]  q_wr;
  logic [AW-1:0]     q_age [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] idx;
  logic              full;
  logic              accept;
  logic              head_ready;
  logic              gate_acc;
  logic              gate_rsp;
  logic              unused_bits;

  assign idx         = addr[ADDR_W+1:2];
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef DATA_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign gate_acc = ~lfsr[0];
  assign gate_rsp = ~lfsr[1];
`else
  assign gate_acc = 1'b1;
  assign gate_rsp = 1'b1;
`endif

  // No bypass: a full queue refuses even when the head retires this cycle.
  assign full       = (count == (PW+1)'(DEPTH));
  assign addr_ok    = ~full & gate_acc;
  assign accept     = req & addr_ok;
  assign head_ready = (count != '0) && (q_age[head] >= AW'(RESP_LAT));
  assign data_ok    = head_ready & gate_rsp;
  assign rdata      = (data_ok && !q_wr[head]) ? q_data[head] : 32'h0;

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      q_data[tail] <= wr ? 32'h0 : mem[idx];
      q_wr[tail]   <= wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q_age[i] <= '0;
    end else begin
      // Ages run for every slot; stale slots are harmless since a push reloads 1.
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (tail == PW'(i)))       q_age[i] <= AW'(1);
        else if (q_age[i] < AW'(RESP_LAT))    q_age[i] <= q_age[i] + AW'(1);
      end
      if (accept)  tail <= tail + PW'(1);
      if (data_ok) head <= head + PW'(1);
      case ({accept, data_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - randomized and directed bench for data_sram_responder (two latencies)
module tb_data_sram_responder;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok_a, data_ok_a, addr_ok_b, data_ok_b;
  logic [31:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .DEPTH(4), .RESP_LAT(2)) u_a (
    .clk(clk), .resetn(resetn), .req(req_a), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a));

  data_sram_responder #(.ADDR_W(10), .DEPTH(4), .RESP_LAT(8)) u_b (
    .clk(clk), .resetn(resetn), .req(req_b), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b));

  typedef struct {logic [31:0] data; bit is_wr; bit known; int acc;} ent_t;
  typedef struct {int cyc; logic [31:0] d;} resp_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    armed = 0;
  ent_t  mq [2][$];
  resp_t logq [2][$];
  logic [31:0] mmem [2][1024];
  bit    mknown [2][1024];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int lat(int k);
    return (k != 0) ? 8 : 2;
  endfunction

  function automatic bit ready(int k);
    return (mq[k].size() > 0) && (cyc - mq[k][0].acc >= lat(k));
  endfunction

  // Reference: queue of accepted requests stamped with their acceptance cycle.
  always @(posedge clk) begin
    if (!resetn) begin
      mq[0].delete();
      mq[1].delete();
      armed = 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit   rq;
        bit   room;
        int   ix;
        ent_t e;
        rq   = (k != 0) ? req_b : req_a;
        room = mq[k].size() < 4;
        if (ready(k)) void'(mq[k].pop_front());
        if (rq && room) begin
          ix = int'(addr[11:2]);
          e.acc = cyc;
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) mmem[k][ix][8*b +: 8] = wdata[8*b +: 8];
            if (wstrb == 4'hF) mknown[k][ix] = 1;
            e.data = 32'h0; e.is_wr = 1; e.known = 1;
          end else begin
            e.data = mmem[k][ix]; e.is_wr = 0; e.known = mknown[k][ix];
          end
          mq[k].push_back(e);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        bit          exp_dok;
        logic [31:0] exp_rd;
        logic        g_aok, g_dok;
        logic [31:0] g_rd;
        g_aok   = (k != 0) ? addr_ok_b : addr_ok_a;
        g_dok   = (k != 0) ? data_ok_b : data_ok_a;
        g_rd    = (k != 0) ? rdata_b : rdata_a;
        exp_dok = ready(k);
        exp_rd  = (exp_dok && !mq[k][0].is_wr) ? mq[k][0].data : 32'h0;
        chk($sformatf("addr_ok[%0d]@%0d", k, cyc), 32'(g_aok), 32'(mq[k].size() < 4));
        chk($sformatf("data_ok[%0d]@%0d", k, cyc), 32'(g_dok), 32'(exp_dok));
        if (!exp_dok || mq[k][0].known)
          chk($sformatf("rdata[%0d]@%0d", k, cyc), g_rd, exp_rd);
        if (g_dok === 1'b1) logq[k].push_back('{cyc, g_rd});
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(int k, bit w, logic [31:0] a, logic [3:0] s, logic [31:0] d, output int acc);
    int n;
    n = 0;
    acc = -1;
    wr = w; addr = a; wstrb = s; wdata = d;
    if (k != 0) req_b = 1'b1; else req_a = 1'b1;
    while (acc < 0 && n < 50) begin
      @(negedge clk);
      if (((k != 0) ? addr_ok_b : addr_ok_a) === 1'b1) acc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, t1, t4;
    int ta [6];
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, t4;
    int ta [6];
    step(2);
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_addr_ok", 32'(addr_ok_a), 32'd1);
      chk("idle_data_ok", 32'(data_ok_a), 32'd0);
      chk("idle_rdata", rdata_a, 32'd0);
    end
    step(1);

    for (int i = 0; i < 16; i++) begin
      issue(0, 1, 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), t0);
      issue(1, 1, 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), t0);
    end
    step(12);

    logq[0].delete();
    issue(0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, t0);
    issue(0, 0, 32'h10, 4'h0, 32'h0, t1);
    step(6);
    chk("raw_gap", 32'(t1 - t0), 32'd1);
    chk("raw_count", 32'(logq[0].size()), 32'd2);
    if (logq[0].size() == 2) begin
      chk("wr_resp_cycle", 32'(logq[0][0].cyc), 32'(t0 + 2));
      chk("wr_resp_rdata", logq[0][0].d, 32'h0);
      chk("rd_resp_cycle", 32'(logq[0][1].cyc), 32'(t0 + 3));
      chk("rd_resp_rdata", logq[0][1].d, 32'hDEAD_BEEF);
    end

    issue(0, 1, 32'h10, 4'hF, 32'h1122_3344, t0);
    issue(0, 1, 32'h10, 4'h2, 32'h0000_AA00, t0);
    issue(0, 0, 32'h10, 4'h0, 32'h0, t0);
    step(6);
    chk("partial_lane1", logq[0][logq[0].size()-1].d, 32'h1122_AA44);
    issue(0, 1, 32'h10, 4'hC, 32'h5566_0000, t0);
    issue(0, 0, 32'h10, 4'h0, 32'h0, t0);
    step(6);
    chk("partial_upper", logq[0][logq[0].size()-1].d, 32'h5566_AA44);

    for (int i = 0; i < 6; i++) issue(0, 1, 32'(i * 4), 4'hF, 32'hF100_0000 | 32'(i), t0);
    step(6);
    logq[0].delete();
    for (int i = 0; i < 6; i++) issue(0, 0, 32'(i * 4), 4'h0, 32'h0, ta[i]);
    step(6);
    chk("flood_count", 32'(logq[0].size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("flood_accept", 32'(ta[i]), 32'(ta[0] + i));
      if (i < logq[0].size()) begin
        chk("flood_cycle", 32'(logq[0][i].cyc), 32'(ta[0] + 2 + i));
        chk("flood_rdata", logq[0][i].d, 32'hF100_0000 | 32'(i));
      end
    end

    logq[1].delete();
    for (int i = 0; i < 4; i++) issue(1, 0, 32'(i * 4), 4'h0, 32'h0, ta[i]);
    issue(1, 0, 32'h20, 4'h0, 32'h0, t4);
    step(16);
    chk("full_held_accept", 32'(t4), 32'(ta[0] + 9));
    chk("full_resp_count", 32'(logq[1].size()), 32'd5);
    if (logq[1].size() == 5) begin
      chk("full_first_cycle", 32'(logq[1][0].cyc), 32'(ta[0] + 8));
      chk("full_fifth_cycle", 32'(logq[1][4].cyc), 32'(t4 + 8));
      chk("full_fifth_rdata", logq[1][4].d, 32'hA000_0008);
    end

    issue(1, 1, 32'h10, 4'hF, 32'hCAFE_F00D, t0);
    step(10);
    logq[1].delete();
    for (int i = 0; i < 3; i++) issue(1, 0, 32'(i * 4), 4'h0, 32'h0, t0);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    step(12);
    chk("reset_drops", 32'(logq[1].size()), 32'd0);
    issue(1, 0, 32'hFFFF_F010, 4'h0, 32'h0, t0);
    step(10);
    chk("reset_persist_n", 32'(logq[1].size()), 32'd1);
    if (logq[1].size() == 1) chk("reset_persist_rdata", logq[1][0].d, 32'hCAFE_F00D);

    for (int i = 0; i < 600; i++) begin
      req_a = 1'($urandom_range(0, 1));
      req_b = $urandom_range(0, 3) != 0;
      wr    = 1'($urandom_range(0, 1));
      addr  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      wstrb = 4'($urandom);
      wdata = $urandom;
      step(1);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
